// File: rtl/cim_array_pingpong_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : cim_array_pingpong_if                                        |
// | Purpose   : Bundles the loader stream, the swap handshake and the        |
// |             inverted weight outputs of cim_array_pingpong.               |
// | Modports  : master - weight DMA / controller side (drives ld_*, swap_req)|
// |             slave  - the CIM array itself                                |
// | Option    : CIM_ARRAY_BANK_MASK_EN adds ld_mask[NUM_BANKS]               |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface cim_array_pingpong_if #(
   parameter int NUM_BANKS = 2,
   parameter int ROWS      = 8,
   parameter int D_W       = 24
) ();

   localparam int c_nw_w = NUM_BANKS * (ROWS / 2) * D_W;

   // Loader stream
   logic              ld_start;
   logic              ld_valid;
   logic              ld_ready;
   logic [D_W-1:0]    ld_data;
   logic              ld_done;
`ifdef CIM_ARRAY_BANK_MASK_EN
   logic [NUM_BANKS-1:0] ld_mask;
`endif

   // Status and plane exchange
   logic              shadow_full;
   logic              busy;
   logic              swap_req;
   logic              swap_ack;
   logic              active_sel;

   // Inverted active-plane weights towards the MAC units
   logic [c_nw_w-1:0] nW_low;
   logic [c_nw_w-1:0] nW_high;

   modport master (
`ifdef CIM_ARRAY_BANK_MASK_EN
      output ld_mask,
`endif
      output ld_start, ld_valid, ld_data, swap_req,
      input  ld_ready, ld_done, shadow_full, busy, swap_ack, active_sel,
      input  nW_low, nW_high
   );

   modport slave (
`ifdef CIM_ARRAY_BANK_MASK_EN
      input  ld_mask,
`endif
      input  ld_start, ld_valid, ld_data, swap_req,
      output ld_ready, ld_done, shadow_full, busy, swap_ack, active_sel,
      output nW_low, nW_high
   );

endinterface
`default_nettype wire

// File: rtl/cim_array_pingpong.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : cim_array_pingpong                                           |
// | Purpose   : Double-buffered CIM weight array. NUM_BANKS x ROWS rows of   |
// |             D_W bits live in two planes. The MAC side reads the inverted |
// |             active plane combinationally while a valid/ready loader      |
// |             fills the shadow plane; swap_req/swap_ack exchanges them.    |
// | Ports     : clk, rst        - clock, asynchronous active-high reset      |
// |             bus (slave)     - ld_start/ld_valid/ld_ready/ld_data/ld_done |
// |                               shadow_full, busy, swap_req/swap_ack,      |
// |                               active_sel, nW_low, nW_high                |
// | Option    : CIM_ARRAY_BANK_MASK_EN - per-bank load mask (bus.ld_mask),   |
// |             sampled at ld_start; masked-off banks keep their contents.   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module cim_array_pingpong #(
   parameter int NUM_BANKS = 2,
   parameter int ROWS      = 8,
   parameter int D_W       = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   cim_array_pingpong_if.slave   bus
);

   localparam int c_row_w  = (ROWS > 1)      ? $clog2(ROWS)      : 1;
   localparam int c_bank_w = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int c_half   = ROWS / 2;
   localparam int c_nw_w   = NUM_BANKS * c_half * D_W;
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [D_W-1:0]        r_plane [2][NUM_BANKS][ROWS];
   logic                  r_active_sel;
   logic                  r_shadow_full;
   logic                  r_swap_ack;
   logic [c_row_w-1:0]    r_row_cnt;
   logic [c_bank_w-1:0]   r_bank_cnt;

   logic                  w_swap_grant;
   logic                  w_load_start;
   logic                  w_accept;
   logic                  w_ld_ready;
   logic                  w_ld_done;
   logic [NUM_BANKS-1:0]  w_mask;
   logic [NUM_BANKS-1:0]  w_start_mask;
   logic                  w_nxt_found;
   logic [c_bank_w-1:0]   w_nxt_bank;
   logic [c_bank_w-1:0]   w_first_bank;
   logic [c_nw_w-1:0]     w_nw_low;
   logic [c_nw_w-1:0]     w_nw_high;

   // ------------------------------------------------------------------
   // Bank enable set: the sampled mask when the option is built in,
   // otherwise every bank takes part in a load.
   // ------------------------------------------------------------------
`ifdef CIM_ARRAY_BANK_MASK_EN
   logic [NUM_BANKS-1:0]  r_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= '0;
      end else if (w_load_start) begin
         r_mask <= bus.ld_mask;
      end
   end

   assign w_mask       = r_mask;
   assign w_start_mask = bus.ld_mask;
`else
   assign w_mask       = '1;
   assign w_start_mask = '1;
`endif

   // Lowest enabled bank strictly above the current one; not found means
   // the bank being filled is the last one of this load.
   always_comb begin
      w_nxt_found = 1'b0;
      w_nxt_bank  = '0;
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
         if (w_mask[b] && (b > int'(r_bank_cnt))) begin
            w_nxt_found = 1'b1;
            w_nxt_bank  = c_bank_w'(b);
         end
      end
   end

   // First enabled bank of the mask presented with ld_start.
   always_comb begin
      w_first_bank = '0;
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
         if (w_start_mask[b]) begin
            w_first_bank = c_bank_w'(b);
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_swap_grant = 1'b0;
      w_load_start = 1'b0;
      w_accept     = 1'b0;
      w_ld_ready   = 1'b0;
      w_ld_done    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A pending swap has priority over a new load request.
            if (r_shadow_full && bus.swap_req) begin
               w_swap_grant = 1'b1;
            end else if (bus.ld_start) begin
               w_load_start = 1'b1;
               w_state_nxt  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_mask == '0) begin
               // Empty mask: nothing to fetch, complete immediately.
               w_state_nxt = ST_DONE;
            end else begin
               w_ld_ready = 1'b1;
               if (bus.ld_valid) begin
                  w_accept = 1'b1;
                  if ((r_row_cnt == c_row_last) && !w_nxt_found) begin
                     w_state_nxt = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            w_ld_done   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Planes, counters and status flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active_sel  <= 1'b0;
         r_shadow_full <= 1'b0;
         r_swap_ack    <= 1'b0;
         r_row_cnt     <= '0;
         r_bank_cnt    <= '0;
         for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
               for (int r = 0; r < ROWS; r++) begin
                  r_plane[p][b][r] <= '0;
               end
            end
         end
      end else begin
         // Ack is reported in the cycle after the exchange edge.
         r_swap_ack <= w_swap_grant;

         if (w_swap_grant) begin
            r_active_sel  <= ~r_active_sel;
            r_shadow_full <= 1'b0;
         end

         if (w_load_start) begin
            r_shadow_full <= 1'b0;
            r_row_cnt     <= '0;
            r_bank_cnt    <= w_first_bank;
         end

         if (w_accept) begin
            // Only the shadow plane is written, so nW_* never glitch.
            r_plane[~r_active_sel][r_bank_cnt][r_row_cnt] <= bus.ld_data;
            if (r_row_cnt == c_row_last) begin
               r_row_cnt <= '0;
               if (w_nxt_found) begin
                  r_bank_cnt <= w_nxt_bank;
               end
            end else begin
               r_row_cnt <= r_row_cnt + 1'b1;
            end
         end

         if (w_ld_done) begin
            r_shadow_full <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Inverted active plane, split into low and high row halves.
   // ------------------------------------------------------------------
   always_comb begin
      w_nw_low  = '0;
      w_nw_high = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         for (int r = 0; r < c_half; r++) begin
            w_nw_low [(b * c_half + r) * D_W +: D_W] = ~r_plane[r_active_sel][b][r];
            w_nw_high[(b * c_half + r) * D_W +: D_W] = ~r_plane[r_active_sel][b][r + c_half];
         end
      end
   end

   assign bus.ld_ready    = w_ld_ready;
   assign bus.ld_done     = w_ld_done;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.shadow_full = r_shadow_full;
   assign bus.swap_ack    = r_swap_ack;
   assign bus.active_sel  = r_active_sel;
   assign bus.nW_low      = w_nw_low;
   assign bus.nW_high     = w_nw_high;

endmodule
`default_nettype wire
